// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and the fetch sequencer state type.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  J_OP     = 6'd2;
  localparam logic [5:0]  JAL_OP   = 6'd3;
  localparam logic [5:0]  ALU_OP   = 6'd0;
  localparam logic [5:0]  JR_FUNCT = 6'd8;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake: request/address out, ack/data back.
interface pc_sequencer_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_target_calc.sv
// Decodes the IDEX instruction into a redirect request, its target and pc+4.
module pc_target_calc #(
  parameter logic [5:0] J_OP     = mips_pkg::J_OP,
  parameter logic [5:0] JAL_OP   = mips_pkg::JAL_OP,
  parameter logic [5:0] ALU_OP   = mips_pkg::ALU_OP,
  parameter logic [5:0] JR_FUNCT = mips_pkg::JR_FUNCT
) (
  input  logic        ex_valid,
  input  logic [5:0]  ex_op,
  input  logic [5:0]  ex_funct,
  input  logic [25:0] ex_jtarget,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  logic is_jump;
  logic is_jr;

  assign is_jump  = (ex_op == J_OP) || (ex_op == JAL_OP);
  assign is_jr    = (ex_op == ALU_OP) && (ex_funct == JR_FUNCT);
  assign redirect = ex_valid & (is_jump | is_jr);
  // Absolute jump index: upper nibble forced to zero, not taken from pc.
  assign target   = is_jump ? {4'b0000, ex_jtarget, 2'b00} : ex_rs_val;
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer feeding the IF/ID register.
// Build option DELAY_SLOT_EN: a redirect keeps the IF/ID instruction as the delay slot.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [5:0]  J_OP     = mips_pkg::J_OP,
  parameter logic [5:0]  JAL_OP   = mips_pkg::JAL_OP,
  parameter logic [5:0]  ALU_OP   = mips_pkg::ALU_OP,
  parameter logic [5:0]  JR_FUNCT = mips_pkg::JR_FUNCT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [5:0]      ex_op,
  input  logic [5:0]      ex_funct,
  input  logic [25:0]     ex_jtarget,
  input  logic [31:0]     ex_rs_val,
  pc_sequencer_if.master  imem,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [31:0]     if_pc,
  output logic            flush,
  output logic [31:0]     pc
);

  mips_pkg::seq_state_t state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] buf_reg, buf_next;
  logic        if_valid_reg, if_valid_next;
  logic        flush_reg, flush_next;

  logic        redirect;
  logic        take_redirect;
  logic        park;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  pc_target_calc #(
    .J_OP(J_OP), .JAL_OP(JAL_OP), .ALU_OP(ALU_OP), .JR_FUNCT(JR_FUNCT)
  ) u_target (
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_jtarget(ex_jtarget), .ex_rs_val(ex_rs_val), .pc(pc_reg),
    .redirect(redirect), .target(target), .pc_plus4(pc_plus4)
  );

  assign take_redirect = redirect && (state_reg != mips_pkg::BOOT);
  // A response that would overwrite a stalled IF/ID entry must be parked.
  assign park          = imem.ack && stall && if_valid_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= mips_pkg::BOOT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      mips_pkg::BOOT:  state_next = mips_pkg::FETCH;
      mips_pkg::FETCH: begin
        if (redirect)  state_next = imem.ack ? mips_pkg::FETCH : mips_pkg::DRAIN;
        else if (park) state_next = mips_pkg::HOLD;
      end
      mips_pkg::HOLD:  if (redirect || !stall) state_next = mips_pkg::FETCH;
      mips_pkg::DRAIN: if (imem.ack) state_next = mips_pkg::FETCH;
      default:         state_next = mips_pkg::BOOT;
    endcase
  end

  always_comb begin
    imem.req = (state_reg == mips_pkg::FETCH) || (state_reg == mips_pkg::DRAIN);
  end

  always_comb begin
    pc_next       = pc_reg;
    if_valid_next = if_valid_reg;
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;
    buf_next      = buf_reg;
    flush_next    = 1'b0;
    if (take_redirect) begin
      pc_next    = target;
      flush_next = 1'b1;
`ifdef DELAY_SLOT_EN
      if_valid_next = if_valid_reg;
`else
      if_valid_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        mips_pkg::FETCH: begin
          if (park) begin
            buf_next = imem.rdata;
          end else if (imem.ack) begin
            if_instr_next = imem.rdata;
            if_pc_next    = pc_reg;
            if_valid_next = 1'b1;
            pc_next       = pc_plus4;
          end
        end
        mips_pkg::HOLD: begin
          if (!stall) begin
            if_instr_next = buf_reg;
            if_pc_next    = pc_reg;
            if_valid_next = 1'b1;
            pc_next       = pc_plus4;
          end
        end
        default: ;
      endcase
    end
    // While draining, the bus must keep presenting the abandoned address.
    addr_next = (state_next == mips_pkg::DRAIN) ? addr_reg : pc_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      if_valid_reg <= 1'b0;
      if_instr_reg <= 32'd0;
      if_pc_reg    <= 32'd0;
      buf_reg      <= 32'd0;
      flush_reg    <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      if_valid_reg <= if_valid_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next;
      buf_reg      <= buf_next;
      flush_reg    <= flush_next;
    end
  end

  assign imem.addr = addr_reg;
  assign if_valid  = if_valid_reg;
  assign if_instr  = if_instr_reg;
  assign if_pc     = if_pc_reg;
  assign flush     = flush_reg;
  assign pc        = pc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_op = 6'd4;
  logic [5:0]  ex_funct = 6'd0;
  logic [25:0] ex_jtarget = 26'd0;
  logic [31:0] ex_rs_val = 32'd0;
  logic        if_valid, flush;
  logic [31:0] if_instr, if_pc, pc;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] SALT = 32'hA5A5_A5A5;

  pc_sequencer_if imem();

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_jtarget(ex_jtarget), .ex_rs_val(ex_rs_val),
    .imem(imem),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .pc(pc)
  );

  // Reference model: booting flag, one outstanding fetch (possibly stale),
  // at most one parked response, and the IF/ID contents.
  bit          m_boot, m_stale, m_held, m_ifv, m_flush;
  logic [31:0] m_pc, m_addr, m_held_data, m_ifi, m_ifp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic bit m_req();
    return !m_boot && !m_held;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_stale = 0; m_held = 0; m_ifv = 0; m_flush = 0;
    m_pc = 32'd0; m_addr = 32'd0; m_held_data = 32'd0; m_ifi = 32'd0; m_ifp = 32'd0;
  endtask

  task automatic model_step();
    bit          redir, ack, is_jump;
    logic [31:0] tgt;
    is_jump = (ex_op == 6'd2) || (ex_op == 6'd3);
    redir   = ex_valid && (is_jump || (ex_op == 6'd0 && ex_funct == 6'd8));
    tgt     = is_jump ? 32'(ex_jtarget) * 32'd4 : ex_rs_val;
    ack     = m_req() && imem.ack;
    m_flush = 0;
    if (m_boot) begin
      m_boot = 0;
    end else begin
      if (redir) begin
        m_pc = tgt;
        m_flush = 1;
`ifndef DELAY_SLOT_EN
        m_ifv = 0;
`endif
        if (m_held)   m_held = 0;
        else if (ack) m_stale = 0;
        else          m_stale = 1;
      end else if (m_held) begin
        if (!stall) begin
          m_ifi = m_held_data; m_ifp = m_pc; m_ifv = 1;
          m_pc = m_pc + 32'd4; m_held = 0;
        end
      end else if (ack) begin
        if (m_stale) m_stale = 0;
        else if (stall && m_ifv) begin
          m_held = 1; m_held_data = imem.rdata;
        end else begin
          m_ifi = imem.rdata; m_ifp = m_pc; m_ifv = 1;
          m_pc = m_pc + 32'd4;
        end
      end
      if (!m_stale) m_addr = m_pc;
    end
  endtask

  task automatic set_ack(input bit a);
    imem.ack   = a && m_req();
    imem.rdata = m_addr ^ SALT;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [25:0] jt, input logic [31:0] rs);
    ex_valid = 1'b1; ex_op = op; ex_funct = fn; ex_jtarget = jt; ex_rs_val = rs;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_op = 6'd4;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    check_eq("req", imem.req, m_req());
    check_eq("addr", imem.addr, m_addr);
    check_eq("if_valid", if_valid, m_ifv);
    check_eq("if_instr", if_instr, m_ifi);
    check_eq("if_pc", if_pc, m_ifp);
    check_eq("flush", flush, m_flush);
    check_eq("pc", pc, m_pc);
    $display("t=%0t req=%b addr=%h ack=%b ifv=%b ifpc=%h flush=%b pc=%h",
             $time, imem.req, imem.addr, imem.ack, if_valid, if_pc, flush, pc);
  endtask

  initial begin
    model_reset();
    imem.ack = 1'b0;
    imem.rdata = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_req", imem.req, 0);
    check_eq("rst_addr", imem.addr, 32'h0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_pc", pc, 32'h0);
    reset = 1'b0;

    // Sequential fetch, ack every cycle
    set_ack(0); cyc();
    check_eq("boot_then_req", imem.req, 1);
    for (int i = 0; i < 4; i++) begin
      set_ack(1); cyc();
      check_eq("seq_addr", imem.addr, 32'(4 * (i + 1)));
      check_eq("seq_if_pc", if_pc, 32'(4 * i));
    end

    // J while a fetch is pending; ack comes 3 cycles later and is dropped
    set_ack(0); issue(6'd2, 6'd0, 26'h000_0100, 32'd0); cyc();
    check_eq("j_flush", flush, 1);
    check_eq("j_hold_addr", imem.addr, 32'h10);
    idle_ex();
    set_ack(0); cyc();
    set_ack(0); cyc();
    set_ack(1); cyc();
    check_eq("j_target_addr", imem.addr, 32'h400);
    check_eq("j_stale_dropped", if_pc, 32'hC);
    set_ack(1); cyc();
    check_eq("j_first_pc", if_pc, 32'h400);

    // JR together with stall: redirect wins
    stall = 1'b1; issue(6'd0, 6'd8, 26'd0, 32'h0000_2000); set_ack(1); cyc();
    check_eq("jr_addr", imem.addr, 32'h2000);
`ifndef DELAY_SLOT_EN
    check_eq("jr_squash", if_valid, 0);
`endif
    stall = 1'b0; idle_ex();

    // Stall for 4 cycles with an ack during the stall
    set_ack(1); cyc();
    stall = 1'b1; set_ack(1); cyc();
    check_eq("hold_req", imem.req, 0);
    for (int i = 0; i < 3; i++) begin
      set_ack(1); cyc();
      check_eq("hold_instr_kept", if_instr, 32'h2000 ^ SALT);
    end
    stall = 1'b0; set_ack(0); cyc();
    check_eq("hold_release_pc", if_pc, 32'h2004);
    check_eq("hold_release_instr", if_instr, 32'h2004 ^ SALT);
    check_eq("hold_pc_step", pc, 32'h2008);

    // Two redirects during a single drain
    set_ack(0); issue(6'd2, 6'd0, 26'h200, 32'd0); cyc();
    set_ack(0); issue(6'd3, 6'd0, 26'h10, 32'd0); cyc();
    idle_ex(); set_ack(1); cyc();
    check_eq("dbl_addr", imem.addr, 32'h40);
    check_eq("dbl_if_pc", if_pc, 32'h2004);
    set_ack(1); cyc();
    check_eq("dbl_fetch_pc", if_pc, 32'h40);

    // pc wraps past the top of the address space
    issue(6'd0, 6'd8, 26'd0, 32'hFFFF_FFFC); set_ack(1); cyc();
    idle_ex(); set_ack(1); cyc();
    check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc", pc, 32'h0);

    // Reset while draining, then a late ack during boot
    set_ack(0); issue(6'd2, 6'd0, 26'h300, 32'd0); cyc();
    idle_ex();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req", imem.req, 0);
    check_eq("mid_rst_addr", imem.addr, 32'h0);
    check_eq("mid_rst_flush", flush, 0);
    check_eq("mid_rst_if_valid", if_valid, 0);
    check_eq("mid_rst_pc", pc, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; model_reset();
    imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF; cyc();
    check_eq("post_rst_addr", imem.addr, 32'h0);
    for (int i = 0; i < 3; i++) begin set_ack(1); cyc(); end

    // Redirect while IF/ID holds pc 8
    set_ack(0); issue(6'd2, 6'd0, 26'h40, 32'd0); cyc();
    check_eq("ds_flush", flush, 1);
    check_eq("ds_if_pc", if_pc, 32'h8);
`ifdef DELAY_SLOT_EN
    check_eq("ds_if_valid", if_valid, 1);
`else
    check_eq("ds_if_valid", if_valid, 0);
`endif
    idle_ex();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      ex_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       ex_op = 6'd2;
        1:       ex_op = 6'd3;
        2:       ex_op = 6'd0;
        default: ex_op = 6'($urandom);
      endcase
      ex_funct   = ($urandom_range(0, 1) == 1) ? 6'd8 : 6'($urandom);
      ex_jtarget = 26'($urandom);
      ex_rs_val  = $urandom & 32'hFFFF_FFFC;
      set_ack($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and drives the instruction-memory fetch handshake for the MIPS pipeline.
- Computes the next PC from the IDEX-stage instruction:
  - J and JAL: target = 26-bit field << 2, upper bits zero.
  - JR (ALU op, funct 8): target = register value.
  - Otherwise: PC+4.
- Sequences fetches around stalls and redirects.
- Sits between the hazard unit / IDEX stage and instruction memory; feeds the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- J_OP, 6'd2, opcode for J.
- JAL_OP, 6'd3, opcode for JAL.
- ALU_OP, 6'd0, R-type opcode.
- JR_FUNCT, 6'd8, funct code for JR.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID contents.
- ex_valid  in  1  IDEX holds a valid instruction this cycle.
- ex_op  in  6  IDEX opcode.
- ex_funct  in  6  IDEX funct field.
- ex_jtarget  in  26  IDEX jump index field.
- ex_rs_val  in  32  forwarded register value for JR.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  32  PC of if_instr.
- flush  out  1  one-cycle pulse: redirect taken.
- pc  out  32  current fetch PC.

Behaviour:
- Reset (async): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, flush=0.
- redirect = ex_valid & (ex_op==J_OP | ex_op==JAL_OP | (ex_op==ALU_OP & ex_funct==JR_FUNCT)).
- target:
  - J/JAL: {4'b0, ex_jtarget, 2'b00}.
  - JR: ex_rs_val.
  - Sequential: pc+4, 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- States:
  - BOOT: one cycle, then FETCH. imem_req=0.
  - FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. Request is never withdrawn before ack.
    - On ack with no redirect and not (stall & if_valid): capture if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+4; stay in FETCH.
    - On ack with stall & if_valid: pc and IF/ID unchanged; response buffered internally; go HOLD.
  - HOLD: imem_req=0.
    - When stall drops: load the buffered instruction into IF/ID next cycle, pc+=4, go FETCH.
  - DRAIN: imem_req stays 1 on the old address; the response is discarded at ack; then FETCH at the updated pc.
- Redirect rules (redirect has priority over stall):
  - In FETCH without ack: pc=target, go DRAIN.
  - In FETCH with ack: discard the data, pc=target, stay FETCH.
  - In HOLD: drop the buffered response, pc=target, go FETCH.
  - In DRAIN: pc=target (latest redirect wins), stay DRAIN.
  - In BOOT: ignored.
  - In every case: flush=1 for exactly the cycle after the redirect is sampled; if_valid=0 (squash) unless DELAY_SLOT_EN.
- Latency:
  - First imem_req at cycle 2 after reset release.
  - Ack-to-if_valid: 1 cycle.
  - Redirect-to-imem_addr=target: 1 cycle, or 1 cycle after the drained ack.
- Reset mid-fetch: everything returns to reset values immediately. A late imem_ack arriving in BOOT is ignored.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined:
  - A redirect does not clear if_valid; the IF/ID instruction is retained as the delay slot.
  - flush still pulses.
  - The in-flight fetch is still discarded.
- Undefined: a redirect clears if_valid (full squash).

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants J_OP, JAL_OP, ALU_OP, JR_FUNCT;
  - the state enum (BOOT, FETCH, HOLD, DRAIN);
  - RESET_PC default.
- One sub-module is natural: pc_target_calc, a combinational block that computes redirect and target.
- Everything else is a single FSM plus registers.

Test Plan:
- Reset then ack every cycle with rdata=addr^32'hA5A5_A5A5 -> imem_addr sequence 0,4,8,C; if_pc lags by one cycle; if_valid=1 from the first ack+1.
- J with ex_jtarget=26'h000_0100 while a fetch is pending (ack delayed 3 cycles) -> flush pulse; if_valid=0; the stale data is dropped; the next imem_addr is 32'h0000_0400.
- JR with ex_rs_val=32'h0000_2000, simultaneous with stall=1 -> redirect wins; next fetch at 32'h2000; if_valid=0.
- stall=1 for 4 cycles, with an ack arriving during the stall -> imem_req=0 in HOLD; if_instr unchanged; the buffered instruction appears the cycle after stall drops; pc advances by exactly 4.
- Two redirects (J then JAL 26'h10) during one DRAIN -> the final fetch is at 32'h40; only the addresses of accepted fetches reach if_pc.
- Assert reset mid-DRAIN with ack still pending -> outputs at reset values immediately; the first post-reset fetch is at RESET_PC.
- With DELAY_SLOT_EN, a J issued while if_valid=1 and if_pc=32'h8 -> if_valid stays 1 with if_pc=8; flush pulses.
